// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the N:1 streaming mux
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_nx1_rr_arb.sv
// rtl/mux_nx1_rr_arb.sv - combinational round-robin arbiter, search starts after ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    input  logic            enable,
    output logic [N_CH-1:0] gnt,
    output logic [SW-1:0]   gnt_idx
);

    int unsigned cur;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cur     = 32'(ptr);
        for (int k = 0; k < N_CH; k++) begin
            cur = wrap_inc(cur, N_CH);
            if (enable && !found && req[cur[SW-1:0]]) begin
                found                = 1'b1;
                gnt[cur[SW-1:0]]     = 1'b1;
                gnt_idx              = cur[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - N:1 streaming mux, fixed or round-robin select, registered output
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    input  logic              out_ready,
    output logic              sel_err
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SW-1:0]   out_ch_q,    out_ch_d;
    logic [SW-1:0]   ptr_q,       ptr_d;
    logic            sel_err_q,   sel_err_d;

    logic            can_accept;
    logic            sel_ok;
    logic            xfer;
    logic [N_CH-1:0] fix_gnt, rr_gnt, gnt;
    logic [SW-1:0]   rr_idx, gnt_idx;
    logic [W-1:0]    gnt_data;

    rr_arbiter #(.N_CH(N_CH), .SW(SW)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .enable  (mode == MODE_RR),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    assign can_accept = !out_valid_q || out_ready;
    assign sel_ok     = 32'(sel) < N_CH;

    always_comb begin
        fix_gnt = '0;
        if (sel_ok && in_valid[sel]) begin
            fix_gnt[sel] = 1'b1;
        end
    end

    assign gnt      = (mode == MODE_RR) ? rr_gnt : fix_gnt;
    assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
    assign in_ready = (rst || !can_accept) ? '0 : gnt;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                gnt_data = in_data[i*W +: W];
            end
        end
    end

    // Load wins over drain so back-to-back beats flow without a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        sel_err_d   = sel_err_q | ((mode == MODE_FIXED) && !sel_ok);
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            if (mode == MODE_RR) begin
                ptr_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= SW'(N_CH - 1);
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - directed table-driven bench for mux_nx1_rr
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: N_CH=4, W=8
    logic        rst, mode, out_ready;
    logic [1:0]  sel;
    logic [3:0]  in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, sel_err;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    mux_nx1_rr #(.N_CH(4), .W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    // Second DUT: N_CH=3 so sel can be out of range
    logic        rst3, mode3, out_ready3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3, in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3, sel_err3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;

    mux_nx1_rr #(.N_CH(3), .W(8)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3), .sel_err(sel_err3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  e_ir;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_ch;
    } vec_t;

    localparam logic [31:0] D = 32'h13121110;
    vec_t tbl[17];

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic [31:0] d, input logic r, input logic [3:0] ir,
                                input logic ov, input logic [7:0] od, input logic [1:0] ch);
        vec_t t;
        t.mode = m; t.sel = s; t.vld = v; t.data = d; t.ordy = r;
        t.e_ir = ir; t.e_ov = ov; t.e_od = od; t.e_ch = ch;
        return t;
    endfunction

    initial begin
        // fixed select ch2
        tbl[0]  = mk(1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        // round-robin, all valid: 0,1,2,3,0
        tbl[1]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        tbl[2]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
        tbl[3]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
        tbl[4]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
        tbl[5]  = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        // ch1+ch3 with backpressure
        tbl[6]  = mk(1'b1, 2'd0, 4'b1010, D, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
        tbl[7]  = mk(1'b1, 2'd0, 4'b1010, D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);
        tbl[8]  = mk(1'b1, 2'd0, 4'b1010, D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);
        tbl[9]  = mk(1'b1, 2'd0, 4'b1010, D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);
        tbl[10] = mk(1'b1, 2'd0, 4'b1010, D, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
        tbl[11] = mk(1'b1, 2'd0, 4'b1010, D, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
        // pointer to 2, fixed sel0 twice, back to rr -> ch3
        tbl[12] = mk(1'b1, 2'd0, 4'b0100, D, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
        tbl[13] = mk(1'b0, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        tbl[14] = mk(1'b0, 2'd0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
        tbl[15] = mk(1'b1, 2'd0, 4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3);
        // no requesters: drain, data/ch hold
        tbl[16] = mk(1'b1, 2'd0, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3);

        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = 4'b1111; in_data = D; out_ready = 1'b1;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; in_valid3 = '0; in_data3 = 24'h222120; out_ready3 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
        check("rst_sel_err", 32'(sel_err), 32'h0);

        @(negedge clk);
        rst = 1'b0; rst3 = 1'b0; in_valid = '0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].vld;
            in_data = tbl[i].data; out_ready = tbl[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            @(posedge clk); #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            check($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(tbl[i].e_ch));
            check($sformatf("v%0d_sel_err", i), 32'(sel_err), 32'h0);
        end

        // Reset with a stalled beat; pointer left at 1 beforehand
        @(negedge clk);
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_out_data", 32'(out_data), 32'h11);
        @(negedge clk);
        in_valid = '0; out_ready = 1'b0; rst = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'h0);
        check("rst_mid_out_data", 32'(out_data), 32'h0);
        check("rst_mid_sel_err", 32'(sel_err), 32'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        check("post_rst_out_ch", 32'(out_ch), 32'h0);
        check("post_rst_out_data", 32'(out_data), 32'h10);

        // N_CH=3: out-of-range select
        @(negedge clk);
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        check("n3_bad_sel_in_ready", 32'(in_ready3), 32'h0);
        @(posedge clk); #1;
        check("n3_bad_sel_out_valid", 32'(out_valid3), 32'h0);
        check("n3_bad_sel_err", 32'(sel_err3), 32'h1);
        @(negedge clk);
        sel3 = 2'd0;
        #1;
        check("n3_sel0_in_ready", 32'(in_ready3), 32'h1);
        @(posedge clk); #1;
        check("n3_sel0_out_data", 32'(out_data3), 32'h20);
        check("n3_sel_err_sticky", 32'(sel_err3), 32'h1);
        // Round-robin wrap on N_CH=3: ch2 then ch0
        @(negedge clk);
        mode3 = 1'b1; in_valid3 = 3'b100;
        @(posedge clk); #1;
        check("n3_rr_ch2", 32'(out_ch3), 32'h2);
        @(negedge clk);
        in_valid3 = 3'b111;
        #1;
        check("n3_rr_wrap_in_ready", 32'(in_ready3), 32'h1);
        @(posedge clk); #1;
        check("n3_rr_wrap_out_ch", 32'(out_ch3), 32'h0);
        check("n3_sel_err_still", 32'(sel_err3), 32'h1);
        @(negedge clk);
        rst3 = 1'b1; in_valid3 = '0;
        @(posedge clk); #1;
        check("n3_rst_sel_err", 32'(sel_err3), 32'h0);
        check("n3_rst_out_valid", 32'(out_valid3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N:1 multiplexer for streaming channels, with a registered output.
- Successor to the combinational 2:1 mux blocks. Adds width and channel-count generality, two select modes (external select or round-robin), and valid/ready handshakes on every channel.
- Sits between N producer channels and one consumer; one output beat per cycle at full throughput.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel.
- SW, $clog2(N_CH), width of select and channel-index fields (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration.
- sel  input  SW  channel index used when mode=0.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH*W  packed channel data; channel i occupies [i*W +: W].
- in_ready  output  N_CH  per-channel ready; at most one bit high.
- out_valid  output  1  output buffer holds a beat.
- out_data  output  W  registered data.
- out_ch  output  SW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts the beat.
- sel_err  output  1  sticky flag: mode=0 with sel >= N_CH was observed.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr pointer=N_CH-1 (first round-robin search starts at channel 0). in_ready=0 while rst=1.
- can_accept = !out_valid || out_ready. The output buffer is a single-entry slice: it loads and drains in the same cycle, with no bubble.
- Grant is combinational from in_valid, mode, sel and the pointer. in_ready[g] = can_accept for the granted channel g; all other bits are 0.
- A transfer on channel i occurs when in_valid[i] && in_ready[i]. On the next edge: out_data = channel i data, out_ch = i, out_valid = 1.
- Latency: 1 cycle from input transfer to out_valid.
- Output drain: if out_valid && out_ready and there is no new transfer, out_valid goes to 0 next cycle. out_data and out_ch hold their last value.
- Output hold: while out_valid && !out_ready, out_data and out_ch are stable and all in_ready bits are 0.
- mode=0 (fixed):
  - Grant sel if sel < N_CH and in_valid[sel]; otherwise no grant.
  - sel >= N_CH: no grant, and sel_err is set at the next edge. sel_err clears only on reset.
  - The rr pointer is not updated in this mode.
- mode=1 (round-robin):
  - Search channels ptr+1, ptr+2, ... modulo N_CH; grant the first one with in_valid set.
  - The pointer is updated to the granted index only when a transfer occurs (not merely on grant).
  - A single requester gets every cycle; there is no forced idle.
- Mode or sel changes take effect in the same cycle (combinational). The beat already in the output buffer is unaffected. The pointer value is retained across mode switches.
- No requester valid: in_ready = all 0 (and 0 while can_accept=0); the output buffer simply drains.
- Wrap-around: when ptr = N_CH-1, the search starts at channel 0.
- Reset mid-operation: a buffered beat is discarded (out_valid=0 next cycle) and the pointer returns to N_CH-1.
- Inputs may deassert in_valid without a transfer; no protocol checking on inputs beyond sel range.

Decomposition:
- Package mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, and a function for the wrapped index increment.
- Sub-module rr_arbiter (N_CH param):
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and binary grant index.
  - Purely combinational; the pointer register stays in mux_nx1_rr.
- The top level holds the output buffer, the pointer, sel_err and the mode mux.

Test Plan (N_CH=4, W=8):
- Reset, then mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
- mode=1, all four valid with data 10/11/12/13, out_ready=1 continuously → outputs in order ch0,1,2,3,0 (10,11,12,13,10), one per cycle with no bubbles.
- mode=1, ch1 and ch3 valid, out_ready=0 for 3 cycles after the first beat → out_data=ch1 held stable, in_ready=0000. After out_ready=1, the next beat is ch3, then ch1.
- mode=0, sel=5 is unreachable with SW=2, so run the sel-range case with N_CH=3, sel=3 → no in_ready, out_valid stays 0, sel_err=1 next cycle and stays 1 until rst.
- Round-robin running (ptr=2), switch to mode=0 with sel=0 for 2 beats, then back to mode=1 with all valid → first round-robin grant is ch3 (pointer retained at 2).
- Assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, sel_err=0; first round-robin grant afterwards is ch0.
